// File: rtl/multi_input_conditioner.sv
// Multi-channel input conditioner: per-channel synchroniser chain, debounce
// counter, clean output level and one-cycle rising/falling edge strobes,
// with a per-channel fault hold and a configurable reset level.
module multi_input_conditioner #(
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned WAIT_TIME   = 4,
    parameter bit          RESET_VALUE = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] noisysignal,
    input  logic [CHANNELS-1:0] faultactive,
    output logic [CHANNELS-1:0] conditioned,
    output logic [CHANNELS-1:0] positiveedge,
    output logic [CHANNELS-1:0] negativeedge
);

    localparam int unsigned CNT_W = (WAIT_TIME > 1) ? $clog2(WAIT_TIME) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_TIME - 1);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        logic [SYNC_STAGES-1:0] sync_q;
        logic [CNT_W-1:0]       cnt_q;
        logic                   cond_q;
        logic                   pos_q;
        logic                   neg_q;
        logic                   s;

        assign s = sync_q[SYNC_STAGES-1];

        // Synchronise the raw pin, debounce it and emit registered edge strobes.
        always_ff @(posedge clk) begin
            if (reset) begin
                sync_q <= {SYNC_STAGES{RESET_VALUE}};
                cond_q <= RESET_VALUE;
                cnt_q  <= '0;
                pos_q  <= 1'b0;
                neg_q  <= 1'b0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], noisysignal[i]};
                pos_q  <= 1'b0;
                neg_q  <= 1'b0;
                if (faultactive[i]) begin
                    cnt_q <= '0;
                end else if (s == cond_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == CNT_MAX) begin
                    cond_q <= s;
                    cnt_q  <= '0;
                    pos_q  <= s;
                    neg_q  <= ~s;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end

        assign conditioned[i]  = cond_q;
        assign positiveedge[i] = pos_q;
        assign negativeedge[i] = neg_q;
    end

endmodule

// File: tb/tb_multi_input_conditioner.sv
// Self-checking bench: two conditioner configurations share one randomized
// stimulus stream and are compared every edge against a window-based model.
module tb_multi_input_conditioner;

    localparam int CH   = 4;
    localparam int MAXE = 3000;

    logic          clk = 1'b0;
    logic          reset;
    logic [CH-1:0] noisy;
    logic [CH-1:0] fault;
    logic [CH-1:0] cond_a, pe_a, ne_a;
    logic [CH-1:0] cond_b, pe_b, ne_b;

    // Default configuration.
    multi_input_conditioner #(.CHANNELS(CH)) dut_a (
        .clk(clk), .reset(reset), .noisysignal(noisy), .faultactive(fault),
        .conditioned(cond_a), .positiveedge(pe_a), .negativeedge(ne_a)
    );

    // Reset-high, single-cycle debounce, three-stage synchroniser.
    multi_input_conditioner #(
        .CHANNELS(CH), .SYNC_STAGES(3), .WAIT_TIME(1), .RESET_VALUE(1'b1)
    ) dut_b (
        .clk(clk), .reset(reset), .noisysignal(noisy), .faultactive(fault),
        .conditioned(cond_b), .positiveedge(pe_b), .negativeedge(ne_b)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    logic [CH-1:0] h_noisy [MAXE];
    logic [CH-1:0] h_fault [MAXE];
    bit            h_reset [MAXE];

    logic [CH-1:0] m_cond [2];
    logic [CH-1:0] m_pe   [2];
    logic [CH-1:0] m_ne   [2];

    task automatic check_eq(input string tag, input logic [CH-1:0] got, input logic [CH-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s edge %0d: got %b expected %b", tag, edge_n, got, exp);
        end
    endtask

    // Synchronised level seen by config c at edge e: the pin sampled SYNC
    // edges earlier, or the reset level if a reset intervened.
    function automatic logic s_at(input int c, input int e, input int i);
        int  st = (c == 0) ? 2 : 3;
        logic rv = (c == 1);
        if (e - st < 0) return rv;
        for (int k = e - st; k < e; k++)
            if (h_reset[k]) return rv;
        return h_noisy[e - st][i];
    endfunction

    // Output changes when the last WAIT edges were all reset-free, fault-free
    // and disagreed with the current output.
    task automatic model_edge(input int c, input int n);
        int   w  = (c == 0) ? 4 : 1;
        logic rv = (c == 1);
        for (int i = 0; i < CH; i++) begin
            m_pe[c][i] = 1'b0;
            m_ne[c][i] = 1'b0;
            if (h_reset[n]) begin
                m_cond[c][i] = rv;
            end else begin
                bit ok = 1'b1;
                for (int j = 0; j < w; j++) begin
                    int e = n - j;
                    if (e < 0) ok = 1'b0;
                    else if (h_reset[e] || h_fault[e][i] || s_at(c, e, i) == m_cond[c][i]) ok = 1'b0;
                end
                if (ok) begin
                    m_cond[c][i] = s_at(c, n, i);
                    m_pe[c][i]   = m_cond[c][i];
                    m_ne[c][i]   = ~m_cond[c][i];
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (edge_n >= MAXE) begin
            $display("FAIL edge_budget edge %0d: got %0d expected < %0d", edge_n, edge_n, MAXE);
            $fatal(1, "edge budget exceeded");
        end
        h_noisy[edge_n] = noisy;
        h_fault[edge_n] = fault;
        h_reset[edge_n] = reset;
        #1;
        model_edge(0, edge_n);
        model_edge(1, edge_n);
        check_eq("a_cond", cond_a, m_cond[0]);
        check_eq("a_pos",  pe_a,   m_pe[0]);
        check_eq("a_neg",  ne_a,   m_ne[0]);
        check_eq("b_cond", cond_b, m_cond[1]);
        check_eq("b_pos",  pe_b,   m_pe[1]);
        check_eq("b_neg",  ne_b,   m_ne[1]);
        edge_n++;
    endtask

    int hold [CH];
    int pulses;

    initial begin
        m_cond[0] = '0; m_cond[1] = '1;
        m_pe[0] = '0; m_pe[1] = '0; m_ne[0] = '0; m_ne[1] = '0;
        reset = 1'b1; noisy = '0; fault = '0;
        tick(); tick();
        check_eq("rst_cond_a", cond_a, 4'b0000);
        check_eq("rst_edges_a", pe_a | ne_a, 4'b0000);
        check_eq("rst_cond_b", cond_b, 4'b1111);
        reset = 1'b0;
        repeat (6) tick();

        // Channel 0 step: visible exactly at the 6th edge, one-cycle strobe.
        noisy[0] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check_eq("lat_cond", cond_a, (k == 6) ? 4'b0001 : 4'b0000);
        end
        check_eq("lat_pos", pe_a, 4'b0001);
        tick();
        check_eq("lat_pos_off", pe_a, 4'b0000);

        // Fast oscillation while high: no change, no strobes.
        for (int k = 0; k < 10; k++) begin
            noisy[0] = ~noisy[0];
            tick();
        end
        noisy[0] = 1'b1;
        repeat (8) tick();
        check_eq("osc_cond", cond_a, 4'b0001);

        // Simultaneous fall on ch1 and rise on ch2.
        noisy[1] = 1'b1;
        repeat (8) tick();
        noisy[1] = 1'b0; noisy[2] = 1'b1;
        repeat (6) tick();
        check_eq("sim_neg", ne_a, 4'b0010);
        check_eq("sim_pos", pe_a, 4'b0100);

        // Fault hold on ch3, then release with the input high.
        fault[3] = 1'b1; noisy[3] = 1'b1;
        pulses = 0;
        repeat (10) begin tick(); pulses += int'(pe_a[3]); end
        check_eq("flt_cond", cond_a & 4'b1000, 4'b0000);
        fault[3] = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            pulses += int'(pe_a[3]);
            if (k <= 4) check_eq("flt_rise", cond_a & 4'b1000, (k == 4) ? 4'b1000 : 4'b0000);
        end
        check_eq("flt_pulses", CH'(pulses), CH'(1));

        // Reset in the middle of a 1->0 debounce on the reset-high config.
        noisy[0] = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
        check_eq("mid_rst_cond_b", cond_b, 4'b1111);
        check_eq("mid_rst_neg_b", ne_b, 4'b0000);
        reset = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check_eq("rst_neg_b0", ne_b & 4'b0001, (k == 4) ? 4'b0001 : 4'b0000);
        end

        // Randomized run: held levels of varying length, glitches, faults, resets.
        for (int i = 0; i < CH; i++) hold[i] = 0;
        repeat (2200) begin
            for (int i = 0; i < CH; i++) begin
                if (hold[i] == 0) begin
                    noisy[i] = 1'($urandom_range(0, 1));
                    hold[i]  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                           : int'($urandom_range(4, 12));
                end else begin
                    hold[i]--;
                end
                fault[i] = fault[i] ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 29) == 0);
            end
            reset = ($urandom_range(0, 249) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_input_conditioner.md
Name: multi_input_conditioner

Overview:
- Parametrised, multi-channel successor to the single-bit input conditioner.
- Each channel takes an asynchronous, bouncy input (button, switch, SPI pin) and passes it through a configurable-depth synchroniser and a configurable debounce counter.
- Each channel produces a clean level plus one-cycle rising and falling edge strobes.
- Adds a per-channel fault-injection hold and a configurable reset level. Sits at the chip boundary, between the pads and the SPI/peripheral logic.

Parameters:
- CHANNELS, 4, number of independent conditioned inputs (>=1).
- SYNC_STAGES, 2, flip-flops in each synchroniser chain (>=2).
- WAIT_TIME, 4, consecutive stable synchronised cycles required before the output changes (>=1).
- RESET_VALUE, 0, single-bit level loaded into every synchroniser stage and every conditioned output on reset.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- noisysignal  input  CHANNELS  raw asynchronous inputs; bit i belongs to channel i.
- faultactive  input  CHANNELS  per-channel fault hold; synchronous, already in the clk domain.
- conditioned  output  CHANNELS  debounced, synchronised level.
- positiveedge  output  CHANNELS  one-cycle pulse when conditioned[i] goes 0->1.
- negativeedge  output  CHANNELS  one-cycle pulse when conditioned[i] goes 1->0.

Behaviour:
- All channels are identical and fully independent. There is no shared state except clk and reset.
- Reset (synchronous, takes priority over everything):
  - every synchroniser stage <= RESET_VALUE
  - conditioned <= RESET_VALUE on all bits
  - counters <= 0
  - positiveedge <= 0, negativeedge <= 0
  - Reset asserted mid-debounce discards the count. Any edge pulse in flight is cleared on that same edge.
- Synchroniser: sync[0] <= noisysignal[i]; sync[k] <= sync[k-1]. Let s = sync[SYNC_STAGES-1].
- Debounce counter: width clog2(WAIT_TIME), minimum 1 bit. On each non-reset edge with faultactive[i] = 0:
  - s == conditioned[i]: counter <= 0. Any glitch restarts the count.
  - s != conditioned[i] and counter == WAIT_TIME-1: conditioned[i] <= s, counter <= 0, and positiveedge[i] <= s or negativeedge[i] <= !s.
  - otherwise: counter <= counter + 1.
  - The counter never exceeds WAIT_TIME-1 and never wraps.
- Edge outputs:
  - Registered. Asserted on the same clock edge that updates conditioned[i].
  - Deasserted on the following edge. Width is exactly one cycle.
  - positiveedge[i] and negativeedge[i] are never both high.
- Latency: an input step that is stable before clock edge 1 updates conditioned on edge SYNC_STAGES + WAIT_TIME. With defaults this is edge 6, so the output is visible just after the 6th rising edge and is unchanged at the first 6 edges.
- faultactive[i] = 1:
  - conditioned[i] holds its value; counter <= 0; both edge outputs <= 0 (this also clears a pending pulse).
  - The synchroniser keeps running.
  - On release, debouncing restarts from count 0. A level that differed during the hold takes the full WAIT_TIME again, with no pulse until it does.
- WAIT_TIME = 1: the output follows s on the first mismatched edge, at latency SYNC_STAGES + 1.
- An input oscillating faster than WAIT_TIME cycles per level never changes conditioned and produces no edges.

Test Plan:
- Defaults; reset high 2 cycles, then low. Check: all outputs 0; conditioned = 4'b0000.
- Ch0 step 0->1 → conditioned[0] = 0 at edges 1..6, 1 just after edge 6. positiveedge[0] is high for exactly cycle 6-7, 0 at #20 later. Channels 1-3 stay 0.
- Ch0 toggled every 7 ns for 10 toggles while conditioned=1, then held at 1 → conditioned[0] stays 1; no edge pulses.
- Ch1 1->0 with ch2 0->1 on the same cycle → negativeedge[1] and positiveedge[2] both pulse on edge 6, one cycle each. Ch0 is unaffected.
- faultactive[3]=1; toggle ch3 to 1 for 10 cycles → conditioned[3] stays 0 with no pulse. Release the hold with the input at 1 → conditioned[3] rises 4 edges later, with a single positiveedge pulse.
- RESET_VALUE=1, WAIT_TIME=1, SYNC_STAGES=3. Assert reset at edge 3 of a 1->0 debounce → conditioned returns to all ones, no negativeedge. After release with input 0 held → negativeedge pulses on edge 4.
